// File: rtl/wb_target_pkg.sv
// rtl/wb_target_pkg.sv - shared types and helpers for the Wishbone target memory
// Purpose: FSM state encoding, byte-select width and the address range check
//          used by wb_target_mem and its interface.
// Ports:   none (package).
package wb_target_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } state_e;

  localparam int WB_SEL_W = 4;

  // True when adr falls inside [base, base + 4*2^depth_log2). Arguments are
  // widened to 64 bits so the window end cannot overflow a 32-bit address.
  function automatic logic addr_in_range(input logic [63:0] adr,
                                         input logic [63:0] base,
                                         input int unsigned depth_log2);
    logic [63:0] span;
    span = 64'd4 << depth_log2;
    return (adr >= base) && ((adr - base) < span);
  endfunction

endpackage

// File: rtl/wb_target_mem_if.sv
// rtl/wb_target_mem_if.sv - Wishbone classic-cycle bus bundle
// Purpose: groups the initiator/target handshake and data signals.
// Ports:   adr, dat_w, sel, we, stb, cyc driven by the master;
//          dat_r, ack, err driven by the slave.
interface wb_target_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  import wb_target_pkg::*;

  logic [ADDR_WIDTH-1:0] adr;
  logic [DATA_WIDTH-1:0] dat_w;
  logic [DATA_WIDTH-1:0] dat_r;
  logic [WB_SEL_W-1:0]   sel;
  logic                  we;
  logic                  stb;
  logic                  cyc;
  logic                  ack;
  logic                  err;

  modport master (
    output adr, dat_w, sel, we, stb, cyc,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, stb, cyc,
    output dat_r, ack, err
  );

endinterface

// File: rtl/wb_target_ram.sv
// rtl/wb_target_ram.sv - single-port RAM with byte write enables
// Purpose: word-addressed storage behind wb_target_mem; kept separate so a
//          vendor macro can replace it.
// Ports:   clock, reset (active-low, clears only the read register),
//          addr (word index), be (per-byte write enable), wdata,
//          re (load rdata), rdata (registered read data).
module wb_target_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DEPTH_LOG2-1:0]   addr,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    re,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  // Array contents are deliberately not reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DATA_WIDTH/8; i++) begin
      if (be[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read register holds its value between read enables.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/wb_target_mem.sv
// rtl/wb_target_mem.sv - Wishbone classic target backed by byte-lane RAM
// Purpose: responds to initiator requests with programmable wait states,
//          error termination on misaligned/out-of-window addresses and a
//          count of completed transfers.
// Ports:   clock, reset (async active-low), bus (slave modport),
//          wait_states (sampled at request accept), txn_count.
module wb_target_mem
  import wb_target_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                clock,
  input  logic                reset,
  wb_target_mem_if.slave      bus,
  input  logic [3:0]          wait_states,
  output logic [31:0]         txn_count
);

  state_e state, next_state;

  logic [3:0]            wcnt;
  logic [DEPTH_LOG2-1:0] lat_idx;
  logic [DATA_WIDTH-1:0] lat_dat;
  logic [WB_SEL_W-1:0]   lat_sel;
  logic                  lat_we;
  logic                  lat_bad;

  logic                  req;
  logic [ADDR_WIDTH-1:0] offset;
  logic [DEPTH_LOG2-1:0] live_idx;
  logic                  live_bad;

  logic [DEPTH_LOG2-1:0] cur_idx;
  logic [DATA_WIDTH-1:0] cur_dat;
  logic [WB_SEL_W-1:0]   cur_sel;
  logic                  cur_we;
  logic                  cur_bad;

  logic                  fire;
  logic                  ack_q;
  logic                  err_q;
  logic [WB_SEL_W-1:0]   ram_be;
  logic                  ram_re;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign req      = bus.cyc & bus.stb;
  assign offset   = bus.adr - BASE_ADDR;
  assign live_idx = DEPTH_LOG2'(offset >> 2);
  assign live_bad = (bus.adr[1:0] != 2'b00) ||
                    !addr_in_range(64'(bus.adr), 64'(BASE_ADDR), DEPTH_LOG2);

  // With zero wait states the RAM access happens on the accept edge itself,
  // before the latches hold anything, so the live bus values are used in IDLE.
  always_comb begin
    cur_idx = lat_idx;
    cur_dat = lat_dat;
    cur_sel = lat_sel;
    cur_we  = lat_we;
    cur_bad = lat_bad;
    if (state == IDLE) begin
      cur_idx = live_idx;
      cur_dat = bus.dat_w;
      cur_sel = bus.sel;
      cur_we  = bus.we;
      cur_bad = live_bad;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (req) begin
          next_state = (wait_states != 4'd0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (!bus.cyc) begin
          next_state = IDLE;
        end else if (wcnt == 4'd1) begin
          next_state = RESP;
        end
      end
      RESP:    next_state = GAP;
      GAP:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The edge that enters RESP raises ack/err and performs the RAM access.
  assign fire   = (next_state == RESP);
  assign ram_be = (fire && !cur_bad && cur_we && reset) ? cur_sel : '0;
  assign ram_re = fire && !cur_bad && !cur_we;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wcnt      <= 4'd0;
      lat_idx   <= '0;
      lat_dat   <= '0;
      lat_sel   <= '0;
      lat_we    <= 1'b0;
      lat_bad   <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      txn_count <= 32'd0;
    end else begin
      state <= next_state;
      ack_q <= fire && !cur_bad;
      err_q <= fire && cur_bad;
      if (fire) begin
        txn_count <= txn_count + 32'd1;
      end
      if (state == IDLE && req) begin
        lat_idx <= live_idx;
        lat_dat <= bus.dat_w;
        lat_sel <= bus.sel;
        lat_we  <= bus.we;
        lat_bad <= live_bad;
        wcnt    <= wait_states;
      end else if (state == WAIT) begin
        wcnt <= wcnt - 4'd1;
      end
    end
  end

  wb_target_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clock (clock),
    .reset (reset),
    .addr  (cur_idx),
    .be    (ram_be),
    .wdata (cur_dat),
    .re    (ram_re),
    .rdata (ram_rdata)
  );

  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.dat_r = ram_rdata;

endmodule

// File: doc/wb_target_mem.md
Name: wb_target_mem

Overview:
- Wishbone classic-cycle target (responder) backed by a word-addressed RAM with byte selects.
- It is the far end of the Wishbone initiator BFM. Smoke benches connect the initiator's bus to it instead of the current loopback-and-auto-ack glue.
- Adds runtime-programmable wait states, error responses and a completed-transfer counter so initiator-side tests can check data integrity, stalls and error paths.

Parameters:
- ADDR_WIDTH, 32, width of adr (byte address).
- DATA_WIDTH, 32, width of dat_r/dat_w; must be 32 (4 byte lanes).
- DEPTH_LOG2, 10, log2 of RAM depth in words.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to 4*2^DEPTH_LOG2.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- adr  input  ADDR_WIDTH  byte address from initiator
- dat_w  input  DATA_WIDTH  write data
- dat_r  output  DATA_WIDTH  read data
- sel  input  4  byte-lane enables
- we  input  1  1 = write, 0 = read
- stb  input  1  strobe
- cyc  input  1  cycle valid
- ack  output  1  normal termination
- err  output  1  error termination
- wait_states  input  4  wait cycles inserted before termination; sampled at request accept
- txn_count  output  32  count of completed (ack or err) transfers

Behaviour:
- Reset (reset low, async): ack=0, err=0, dat_r=0, txn_count=0, FSM=IDLE, pending transfer discarded. RAM contents are not reset.
- Request is present when cyc & stb.
- FSM states: IDLE, WAIT, RESP, GAP.
- IDLE:
  - On a request, latch adr/dat_w/sel/we and load wcnt=wait_states.
  - Go to WAIT if wait_states != 0, else RESP.
- WAIT:
  - If cyc drops, return to IDLE with no write and no termination (abort).
  - Otherwise decrement wcnt; move to RESP when wcnt reaches 1.
- RESP:
  - Registered ack or err is high for exactly one cycle.
  - The write commits at the same edge that raises ack.
  - Next state is GAP.
- GAP:
  - One idle cycle, so ack/err are never high on consecutive cycles.
  - Next state is IDLE.
- Latency: request sampled at edge N → ack/err high during cycle N+1+wait_states. Peak throughput is 1 transfer per 3 cycles.
- Error (err instead of ack) when either:
  - adr[1:0] != 0, or
  - adr is outside BASE_ADDR .. BASE_ADDR+4*2^DEPTH_LOG2-1.
- On error: no RAM write, dat_r unchanged.
- sel == 0: legal; write changes nothing, read still returns the full word, ack given.
- Word index = (adr - BASE_ADDR) >> 2, truncated to DEPTH_LOG2 bits.
- Write: byte lane i is updated iff sel[i].
- Read: dat_r is loaded with the full word at the RAM edge that raises ack. dat_r holds its value until the next read ack.
- ack and err are never both high.
- Changes to wait_states after a request is accepted do not affect that transfer.
- txn_count increments by 1 on each ack or err cycle and wraps modulo 2^32.
- stb dropping while cyc stays high during WAIT: transfer still completes (latched request).
- reset asserted in WAIT or RESP: ack/err drop immediately; no write occurs unless the write edge has already passed.

Decomposition:
- Package wb_target_pkg:
  - state_e enum (IDLE, WAIT, RESP, GAP)
  - WB_SEL_W = 4
  - function addr_in_range(adr, base, depth_log2)
- Sub-module wb_target_ram:
  - single-port synchronous RAM with per-byte write enable and a registered read port.
  - Parameters DATA_WIDTH and DEPTH_LOG2.
  - Allows swapping in a vendor RAM.

Test Plan:
- Single access, wait_states=0: write 0xDEADBEEF to 0x10 with sel=4'hF, then read 0x10 → ack 1 cycle after each request, read data 0xDEADBEEF, txn_count=2.
- Byte lanes: write 0x11223344 to 0x20 (sel=F), then write 0xAABBCCDD with sel=4'b0101, then read 0x20 → 0x11BB33DD.
- wait_states=3: read request at edge N → ack exactly in cycle N+4. Change wait_states to 0 during the WAIT → latency still 4.
- Errors:
  - Read 0x1002 (misaligned) → err=1, ack=0, dat_r unchanged.
  - Write to BASE_ADDR+0x1000 with DEPTH_LOG2=10 → err; readback of word 0 is unchanged.
  - txn_count counts both errors.
- Abort: wait_states=5, write to 0x40, drop cyc after 2 cycles → no ack/err, RAM word at 0x40 unchanged, txn_count unchanged, next request served normally.
- Reset mid-transfer: assert reset during WAIT → ack/err/dat_r/txn_count 0 immediately. After release, a back-to-back write/read pair at 0x8 returns the written data with ack never high on consecutive cycles.
